// File: rtl/shift_exec_pkg.sv
// Shared definitions for the iterative shift/rotate unit: op encodings and FSM states.
package shift_exec_pkg;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_stage.sv
// One conditional shift/rotate by 2^k; purely combinational, reused once per iteration.
module shift_stage
    import shift_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] k_i,
    input  logic             en_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [AMT_W:0] WidthL = (AMT_W+1)'(WIDTH);

    logic [AMT_W:0] sh_amt;
    logic [AMT_W:0] wrap_amt;

    // k never exceeds AMT_W-1, so the stage distance is at most WIDTH/2
    assign sh_amt   = (AMT_W+1)'(1) << k_i;
    assign wrap_amt = WidthL - sh_amt;

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            unique case (op_i)
                OP_ROL:  data_o = (data_i << sh_amt) | (data_i >> wrap_amt);
                OP_SLL:  data_o = data_i << sh_amt;
                OP_ROR:  data_o = (data_i >> sh_amt) | (data_i << wrap_amt);
                OP_SRL:  data_o = data_i >> sh_amt;
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shift_exec.sv
// Iterative barrel shifter: one binary stage per cycle, ready/valid in and out, kill abort.
// Define SHIFT_EXEC_ZERO_BYPASS_EN to send zero-amount operations straight to DONE.
module shift_exec
    import shift_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [AMT_W-1:0] in_amt_i,
    input  logic [1:0]       in_op_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);

    localparam logic [AMT_W-1:0] KLast = AMT_W'(AMT_W - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [AMT_W-1:0] k_q, k_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] stage_out;
    logic             zero_bypass;

    shift_stage #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_stage (
        .data_i (data_q),
        .k_i    (k_q),
        .en_i   (amt_q[0]),
        .op_i   (op_q),
        .data_o (stage_out)
    );

`ifdef SHIFT_EXEC_ZERO_BYPASS_EN
    assign zero_bypass = (in_amt_i == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        k_d     = k_q;
        op_d    = op_q;
        if (kill_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        data_d  = in_data_i;
                        amt_d   = in_amt_i;
                        op_d    = in_op_i;
                        k_d     = '0;
                        state_d = zero_bypass ? StDone : StShift;
                    end
                end
                StShift: begin
                    // amt is consumed LSB-first so bit 0 always gates the current stage
                    data_d = stage_out;
                    amt_d  = amt_q >> 1;
                    k_d    = k_q + AMT_W'(1);
                    if (k_q == KLast) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            amt_q   <= '0;
            k_q     <= '0;
            op_q    <= OP_ROL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            k_q     <= k_d;
            op_q    <= op_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign out_data_o  = data_q;

endmodule
